timestamp_mem_loader: RTL and testbench

- Write-side producer for the double-buffered timestamp/active-pixel memory groups.
- Accepts a stream of 17-bit words (bit 16 = active pixel, bits 15:0 = timestamp) from the host/DMA side over a valid/ready handshake.
- Sequences the words into per-frame groups (waddr, wdata, wen, memory selector) for the memory manager's write port.
- Raises mem_updated once the full set of groups is written, and holds it until the manager swaps banks.

---
 rtl/timestamp_mem_loader_pkg.sv | 22 ++
 rtl/timestamp_mem_loader_addr_gen.sv | 39 +++
 rtl/timestamp_mem_loader.sv | 113 +++++++++++
 tb/tb_timestamp_mem_loader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timestamp_mem_loader_pkg.sv
// Constants and FSM encoding shared by the timestamp memory loader and the
// manager's read side.
package timestamp_mem_loader_pkg;

   localparam int ACTIVE_BIT = 16;
   localparam int DATA_W     = ACTIVE_BIT + 1;
   localparam int ADDR_W     = 9;
   localparam int GRP_W      = 3;
   localparam int MAX_GRP    = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Requests beyond the last physical group load every group instead.
   function automatic logic [GRP_W-1:0] clamp_frames(input logic [GRP_W-1:0] frames);
      return (frames > GRP_W'(MAX_GRP)) ? GRP_W'(MAX_GRP) : frames;
   endfunction

endpackage

// File: rtl/timestamp_mem_loader_addr_gen.sv
// Word/group address counters for the loader; flags the final word of the
// final group so the FSM can close the load.
module loader_addr_gen
   import timestamp_mem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              nrst,
   input  logic              clear,
   input  logic              step,
   input  logic [ADDR_W-1:0] last_addr,
   input  logic [GRP_W-1:0]  frames,
   output logic [ADDR_W-1:0] addr_cnt,
   output logic [GRP_W-1:0]  grp_cnt,
   output logic              last_word_w
);

   logic group_end;

   assign group_end   = (addr_cnt == last_addr);
   assign last_word_w = group_end & (grp_cnt == frames);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         addr_cnt <= '0;
         grp_cnt  <= '0;
      end else if (clear) begin
         addr_cnt <= '0;
         grp_cnt  <= '0;
      end else if (step) begin
         if (group_end) begin
            addr_cnt <= '0;
            grp_cnt  <= grp_cnt + GRP_W'(1);
         end else begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
         end
      end
   end

endmodule

// File: rtl/timestamp_mem_loader.sv
// Write-side producer for the double-buffered timestamp/active-pixel groups:
// streams words into groups, then requests a bank swap via mem_updated_o.
module timestamp_mem_loader
   import timestamp_mem_loader_pkg::*;
(
   input  logic              clk_i,
   input  logic              nrst_i,
   input  logic              load_start_i,
   input  logic              abort_i,
   input  logic [GRP_W-1:0]  number_of_frames_i,
   input  logic [ADDR_W-1:0] last_addr_i,
   input  logic              s_valid_i,
   input  logic [DATA_W-1:0] s_data_i,
   output logic              s_ready_o,
   output logic [ADDR_W-1:0] waddr_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              wen_o,
   output logic [GRP_W-1:0]  memory_selector_o,
   input  logic              update_mem_i,
   output logic              mem_updated_o,
   output logic              busy_o,
   output logic              load_done_o,
   output logic              overrun_o
);

   state_t            state;
   logic [GRP_W-1:0]  frames_sh;
   logic [ADDR_W-1:0] last_sh;
   logic              upd_ref;
   logic              xfer;
   logic              clear;
   logic              last_word_w;
   logic [ADDR_W-1:0] addr_cnt;
   logic [GRP_W-1:0]  grp_cnt;

   // Stream handshake: a word moves when s_valid_i & s_ready_o; abort_i
   // withdraws ready so a word offered in the abort cycle is never taken.
   assign s_ready_o = (state == ST_LOAD) & ~abort_i;
   assign xfer      = s_valid_i & s_ready_o;
   assign clear     = (state == ST_IDLE) & load_start_i;
   assign busy_o    = (state != ST_IDLE);

   loader_addr_gen u_addr_gen (
      .clk         (clk_i),
      .nrst        (nrst_i),
      .clear       (clear),
      .step        (xfer),
      .last_addr   (last_sh),
      .frames      (frames_sh),
      .addr_cnt    (addr_cnt),
      .grp_cnt     (grp_cnt),
      .last_word_w (last_word_w)
   );

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state             <= ST_IDLE;
         frames_sh         <= '0;
         last_sh           <= '0;
         upd_ref           <= 1'b0;
         wen_o             <= 1'b0;
         waddr_o           <= '0;
         wdata_o           <= '0;
         memory_selector_o <= '0;
         mem_updated_o     <= 1'b0;
         load_done_o       <= 1'b0;
         overrun_o         <= 1'b0;
      end else begin
         wen_o       <= xfer;
         load_done_o <= 1'b0;
         if (xfer) begin
            waddr_o           <= addr_cnt;
            wdata_o           <= s_data_i;
            memory_selector_o <= grp_cnt;
         end
         if (load_start_i && (state != ST_IDLE))
            overrun_o <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (load_start_i) begin
                  frames_sh <= clamp_frames(number_of_frames_i);
                  last_sh   <= last_addr_i;
                  state     <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (abort_i) begin
                  state <= ST_IDLE;
               end else if (xfer && last_word_w) begin
                  upd_ref <= update_mem_i;
                  state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               // Any change of the manager's bank-select level means the swap happened.
               if (abort_i) begin
                  mem_updated_o <= 1'b0;
                  state         <= ST_IDLE;
               end else if (update_mem_i != upd_ref) begin
                  mem_updated_o <= 1'b0;
                  load_done_o   <= 1'b1;
                  state         <= ST_IDLE;
               end else begin
                  mem_updated_o <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_timestamp_mem_loader.sv
// Self-checking bench for timestamp_mem_loader: table-driven load scenarios,
// randomized configurations and gaps, plus abort/overrun/reset sequences.
module tb_timestamp_mem_loader;

   logic        clk_i = 1'b0;
   logic        nrst_i;
   logic        load_start_i;
   logic        abort_i;
   logic [2:0]  number_of_frames_i;
   logic [8:0]  last_addr_i;
   logic        s_valid_i;
   logic [16:0] s_data_i;
   logic        s_ready_o;
   logic [8:0]  waddr_o;
   logic [16:0] wdata_o;
   logic        wen_o;
   logic [2:0]  memory_selector_o;
   logic        update_mem_i;
   logic        mem_updated_o;
   logic        busy_o;
   logic        load_done_o;
   logic        overrun_o;

   int          checks = 0;
   int          errors = 0;
   int          wen_count = 0;
   logic        exp_ovr = 1'b0;
   logic [28:0] exp_q[$];

   typedef struct {
      logic [2:0] fr;
      logic [8:0] la;
      int         gap;
      int         abort_at;
      logic       ovr;
      int         exp_writes;
   } vec_t;

   vec_t vecs[10];

   timestamp_mem_loader dut (
      .clk_i              (clk_i),
      .nrst_i             (nrst_i),
      .load_start_i       (load_start_i),
      .abort_i            (abort_i),
      .number_of_frames_i (number_of_frames_i),
      .last_addr_i        (last_addr_i),
      .s_valid_i          (s_valid_i),
      .s_data_i           (s_data_i),
      .s_ready_o          (s_ready_o),
      .waddr_o            (waddr_o),
      .wdata_o            (wdata_o),
      .wen_o              (wen_o),
      .memory_selector_o  (memory_selector_o),
      .update_mem_i       (update_mem_i),
      .mem_updated_o      (mem_updated_o),
      .busy_o             (busy_o),
      .load_done_o        (load_done_o),
      .overrun_o          (overrun_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) if (wen_o === 1'b1) wen_count++;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock of stimulus; a word the model says is accepted must appear
   // on the write port exactly one cycle later.
   task automatic step(input logic v, input logic [16:0] d, input logic exp_rdy);
      logic [28:0] e;
      s_valid_i = v;
      s_data_i  = d;
      #1;
      check("s_ready", s_ready_o, exp_rdy);
      @(posedge clk_i);
      #1;
      s_valid_i    = 1'b0;
      load_start_i = 1'b0;
      if (v && exp_rdy) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
         end else begin
            e = exp_q.pop_front();
            check("wen", wen_o, 1);
            check("waddr", waddr_o, e[25:17]);
            check("wdata", wdata_o, e[16:0]);
            check("sel", memory_selector_o, e[28:26]);
         end
      end else begin
         check("wen_idle", wen_o, 0);
      end
   endtask

   task automatic run_load(input logic [2:0] fr, input logic [8:0] la, input int gap_mode,
                           input int abort_at, input logic ovr, input int exp_writes);
      int          per, total, sent, iter, w0;
      logic        v;
      logic [16:0] d;
      per   = int'(la) + 1;
      total = ((fr > 3'd4) ? 5 : int'(fr) + 1) * per;
      w0    = wen_count;
      number_of_frames_i = fr;
      last_addr_i        = la;
      load_start_i       = 1'b1;
      @(posedge clk_i);
      #1;
      load_start_i = 1'b0;
      check("busy_start", busy_o, 1);
      sent = 0;
      iter = 0;
      while (sent < total && iter < 4 * total + 16) begin
         iter++;
         if (sent == abort_at) begin
            abort_i = 1'b1;
            step(1'b1, 17'h1abcd, 1'b0);
            abort_i = 1'b0;
            check("abort_busy", busy_o, 0);
            check("abort_mem_upd", mem_updated_o, 0);
            check("abort_writes", wen_count - w0, exp_writes);
            return;
         end
         case (gap_mode)
            0:       v = 1'b1;
            1:       v = (iter % 2 == 1);
            default: v = 1'($urandom_range(0, 1));
         endcase
         d = (gap_mode == 2) ? 17'($urandom) : 17'h10000 + 17'(sent);
         if (ovr && sent == 1 && v) begin
            load_start_i = 1'b1;
            exp_ovr      = 1'b1;
         end
         if (v) exp_q.push_back({3'(sent / per), 9'(sent % per), d});
         step(v, d, 1'b1);
         if (v) sent++;
      end
      if (sent < total) begin
         checks++;
         errors++;
         $display("FAIL load_timeout: got %0d words expected %0d", sent, total);
      end
      check("done_busy", busy_o, 1);
      check("mem_upd_first_done", mem_updated_o, 0);
      if (ovr) begin
         load_start_i = 1'b1;
         exp_ovr      = 1'b1;
      end
      step(1'b1, 17'h05555, 1'b0);
      check("mem_upd", mem_updated_o, 1);
      check("overrun", overrun_o, exp_ovr);
      repeat ($urandom_range(0, 3)) begin
         step(1'b0, 17'h0, 1'b0);
         check("mem_upd_hold", mem_updated_o, 1);
         check("load_done_low", load_done_o, 0);
      end
      if (abort_at == total) begin
         abort_i = 1'b1;
         @(posedge clk_i);
         #1;
         abort_i = 1'b0;
         check("done_abort_mem_upd", mem_updated_o, 0);
         check("done_abort_no_pulse", load_done_o, 0);
         check("done_abort_busy", busy_o, 0);
      end else begin
         update_mem_i = ~update_mem_i;
         @(posedge clk_i);
         #1;
         check("load_done_pulse", load_done_o, 1);
         check("swap_mem_upd", mem_updated_o, 0);
         check("swap_busy", busy_o, 0);
         @(posedge clk_i);
         #1;
         check("load_done_end", load_done_o, 0);
      end
      check("writes", wen_count - w0, exp_writes);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wen"}, wen_o, 0);
      check({tag, "_waddr"}, waddr_o, 0);
      check({tag, "_wdata"}, wdata_o, 0);
      check({tag, "_sel"}, memory_selector_o, 0);
      check({tag, "_mem_upd"}, mem_updated_o, 0);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_load_done"}, load_done_o, 0);
      check({tag, "_overrun"}, overrun_o, 0);
      check({tag, "_ready"}, s_ready_o, 0);
   endtask

   initial begin
      logic [2:0]  rfr;
      logic [8:0]  rla;
      logic [16:0] d;
      int          rtot;

      vecs[0] = '{3'd1, 9'd3,   0, -1, 1'b0, 8};
      vecs[1] = '{3'd1, 9'd3,   1, -1, 1'b0, 8};
      vecs[2] = '{3'd7, 9'd0,   0, -1, 1'b0, 5};
      vecs[3] = '{3'd1, 9'd3,   0,  3, 1'b0, 3};
      vecs[4] = '{3'd0, 9'd5,   2, -1, 1'b0, 6};
      vecs[5] = '{3'd1, 9'd3,   0, -1, 1'b1, 8};
      vecs[6] = '{3'd0, 9'd0,   0, -1, 1'b0, 1};
      vecs[7] = '{3'd2, 9'd1,   2,  6, 1'b0, 6};
      vecs[8] = '{3'd4, 9'd511, 0, -1, 1'b0, 2560};
      vecs[9] = '{3'd5, 9'd2,   2, -1, 1'b1, 15};

      nrst_i = 1'b0;
      load_start_i = 1'b0;
      abort_i = 1'b0;
      number_of_frames_i = '0;
      last_addr_i = '0;
      s_valid_i = 1'b0;
      s_data_i = '0;
      update_mem_i = 1'b0;
      #1;
      check_all_zero("reset");
      repeat (3) @(posedge clk_i);
      #1;
      nrst_i = 1'b1;

      for (int i = 0; i < 10; i++)
         run_load(vecs[i].fr, vecs[i].la, vecs[i].gap, vecs[i].abort_at, vecs[i].ovr,
                  vecs[i].exp_writes);

      for (int i = 0; i < 6; i++) begin
         rfr  = 3'($urandom_range(0, 7));
         rla  = 9'($urandom_range(0, 12));
         rtot = ((rfr > 3'd4) ? 5 : int'(rfr) + 1) * (int'(rla) + 1);
         run_load(rfr, rla, 2, -1, 1'b0, rtot);
      end

      // Reset in the middle of a load clears every output at once.
      number_of_frames_i = 3'd1;
      last_addr_i        = 9'd3;
      load_start_i       = 1'b1;
      @(posedge clk_i);
      #1;
      load_start_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         d = 17'($urandom);
         exp_q.push_back({3'd0, 9'(k), d});
         step(1'b1, d, 1'b1);
      end
      #2;
      nrst_i = 1'b0;
      #1;
      check_all_zero("midreset");
      @(posedge clk_i);
      #1;
      nrst_i  = 1'b1;
      exp_ovr = 1'b0;
      check("post_reset_busy", busy_o, 0);
      run_load(3'd1, 9'd3, 0, -1, 1'b0, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
